sd_cmd_sequencer: RTL and testbench

Host-side SD command sequencer for the control path. Queues commands (index, argument, response flag) in a parametrised FIFO and issues them one at a time to the command physical layer over a four-phase strobe/ack handshake. It then collects the 38-bit response under a cycle timeout, retries failed commands, and reports a status per command. This is the synthesizable successor to the fixed single-command stimulus sequence used to bring up the command path.

---
 rtl/sd_ctrl_pkg.sv | 33 +++
 rtl/sd_cmd_fifo.sv | 55 +++++
 rtl/sd_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_ctrl_pkg.sv
// Shared types and field widths for the SD host command path.
package sd_ctrl_pkg;

    localparam int CMD_IDX_W = 6;
    localparam int CMD_ARG_W = 32;
    localparam int RESP_W    = 38;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_WAIT_RSP,
        S_ACK_RSP,
        S_ACK_DONE,
        S_RETRY_CHK,
        S_REPORT
    } state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_ERROR   = 2'b10
    } status_e;

    typedef struct packed {
        logic                 no_resp;
        logic [CMD_IDX_W-1:0] index;
        logic [CMD_ARG_W-1:0] argument;
    } cmd_entry_t;

    localparam int CMD_ENTRY_W = $bits(cmd_entry_t);

endpackage

// File: rtl/sd_cmd_fifo.sv
// Command queue: DEPTH-entry synchronous FIFO with occupancy count and
// a combinational read of the head entry.
module sd_cmd_fifo
    import sd_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [CMD_ENTRY_W-1:0] wdata_i,
    input  logic                   pop_i,
    output logic [CMD_ENTRY_W-1:0] rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [CMD_ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wptr_q, rptr_q;
    logic [AW:0]            count_q;
    logic                   do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // Push only checks fullness, so a push alongside a pop at count<DEPTH is fine.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Host-side SD command sequencer: queues commands, issues them to the phy over
// a four-phase handshake, collects responses under timeout and retries failures.
module sd_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 2,
    parameter int RESP_W         = 38
) (
    input  logic                   iClock_host,
    input  logic                   iReset_n,
    input  logic                   iCmd_valid,
    output logic                   oCmd_ready,
    input  logic [5:0]             iCmd_index,
    input  logic [31:0]            iCmd_argument,
    input  logic                   iCmd_no_resp,
    output logic                   oStrobe_out,
    output logic [5:0]             oCmd_index,
    output logic [31:0]            oCmd_argument,
    input  logic                   iAck_in,
    input  logic                   iStrobe_in,
    input  logic [RESP_W-1:0]      iResponse,
    input  logic                   iResp_error,
    output logic                   oAck_out,
    output logic                   oRsp_valid,
    input  logic                   iRsp_ready,
    output logic [5:0]             oRsp_index,
    output logic [RESP_W-1:0]      oRsp_data,
    output logic [1:0]             oRsp_status,
    output logic                   oBusy,
    output logic [$clog2(DEPTH):0] oQueue_count
);

    import sd_ctrl_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_e              state_q;
    cmd_entry_t          cmd_q, head_s, push_s;
    logic [TW-1:0]       timer_q;
    logic [RW-1:0]       retry_q;
    logic                err_q;
    logic                strobe_q, ack_q, rsp_valid_q, busy_q;
    logic [1:0]          status_q;
    logic [RESP_W-1:0]   rsp_data_q;
    logic                fifo_full, fifo_empty, fifo_pop;
    logic [CMD_ENTRY_W-1:0] fifo_rdata;

    assign push_s   = {iCmd_no_resp, iCmd_index, iCmd_argument};
    assign head_s   = cmd_entry_t'(fifo_rdata);
    assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;

    sd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (iClock_host),
        .rst_ni  (iReset_n),
        .push_i  (iCmd_valid),
        .wdata_i (push_s),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (oQueue_count)
    );

    assign oCmd_ready    = !fifo_full;
    assign oStrobe_out   = strobe_q;
    assign oAck_out      = ack_q;
    assign oRsp_valid    = rsp_valid_q;
    assign oBusy         = busy_q;
    assign oCmd_index    = cmd_q.index;
    assign oCmd_argument = cmd_q.argument;
    assign oRsp_index    = cmd_q.index;
    assign oRsp_data     = rsp_data_q;
    assign oRsp_status   = status_q;

    always_ff @(posedge iClock_host or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            timer_q     <= '0;
            retry_q     <= '0;
            err_q       <= 1'b0;
            strobe_q    <= 1'b0;
            ack_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            status_q    <= ST_OK;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (!fifo_empty) begin
                    cmd_q    <= head_s;
                    retry_q  <= '0;
                    strobe_q <= 1'b1;
                    busy_q   <= 1'b1;
                    state_q  <= S_ISSUE;
                end
                S_ISSUE: if (iAck_in) begin
                    strobe_q <= 1'b0;
                    state_q  <= S_RELEASE;
                end
                S_RELEASE: if (!iAck_in) begin
                    if (cmd_q.no_resp) begin
                        status_q    <= ST_OK;
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_REPORT;
                    end else begin
                        timer_q <= '0;
                        state_q <= S_WAIT_RSP;
                    end
                end
                // A response in the last timer cycle takes priority over timeout.
                S_WAIT_RSP: begin
                    if (iStrobe_in) begin
                        rsp_data_q <= iResponse;
                        err_q      <= iResp_error;
                        ack_q      <= 1'b1;
                        state_q    <= S_ACK_RSP;
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        status_q   <= ST_TIMEOUT;
                        rsp_data_q <= '0;
                        state_q    <= S_RETRY_CHK;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_ACK_RSP: if (!iStrobe_in) begin
                    ack_q   <= 1'b0;
                    state_q <= S_ACK_DONE;
                end
                S_ACK_DONE: begin
                    if (err_q) begin
                        status_q <= ST_ERROR;
                        state_q  <= S_RETRY_CHK;
                    end else begin
                        status_q    <= ST_OK;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_REPORT;
                    end
                end
                S_RETRY_CHK: begin
                    if (int'(retry_q) < MAX_RETRY) begin
                        retry_q  <= retry_q + RW'(1);
                        strobe_q <= 1'b1;
                        state_q  <= S_ISSUE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_REPORT;
                    end
                end
                S_REPORT: if (iRsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench: directed handshake/timeout/queue scenarios plus random
// commands checked against an attempt-level reference model.
module tb_sd_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TOUT  = 16;
    localparam int MAXR  = 2;
    localparam int RW    = 38;
    localparam logic [1:0] OK = 2'b00, TO = 2'b01, ER = 2'b10;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_no_resp = 1'b0;
    logic [5:0]    cmd_index = '0;
    logic [31:0]   cmd_arg = '0;
    logic          ack_in = 1'b0, strobe_in = 1'b0, resp_error = 1'b0, rsp_ready = 1'b0;
    logic [RW-1:0] response = '0;
    logic          cmd_ready, strobe_out, ack_out, rsp_valid, busy;
    logic [5:0]    o_idx, rsp_idx;
    logic [31:0]   o_arg;
    logic [RW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic [$clog2(DEPTH):0] qcount;

    int n_tests = 0, n_fail = 0;
    int strobe_rises = 0, ack_rises = 0;

    always #5 clk = ~clk;

    sd_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT), .MAX_RETRY(MAXR), .RESP_W(RW)) dut (
        .iClock_host(clk), .iReset_n(rst_n),
        .iCmd_valid(cmd_valid), .oCmd_ready(cmd_ready),
        .iCmd_index(cmd_index), .iCmd_argument(cmd_arg), .iCmd_no_resp(cmd_no_resp),
        .oStrobe_out(strobe_out), .oCmd_index(o_idx), .oCmd_argument(o_arg),
        .iAck_in(ack_in), .iStrobe_in(strobe_in), .iResponse(response),
        .iResp_error(resp_error), .oAck_out(ack_out),
        .oRsp_valid(rsp_valid), .iRsp_ready(rsp_ready),
        .oRsp_index(rsp_idx), .oRsp_data(rsp_data), .oRsp_status(rsp_status),
        .oBusy(busy), .oQueue_count(qcount)
    );

    always @(posedge strobe_out) strobe_rises++;
    always @(posedge ack_out) ack_rises++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return strobe_out;
            1:       return ack_out;
            2:       return rsp_valid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int sel, input logic lvl);
        int n = 0;
        while (probe(sel) !== lvl && n < 300) begin
            tick();
            n++;
        end
        chk(tag, probe(sel), lvl);
    endtask

    task automatic push(input logic [5:0] idx, input logic [31:0] arg, input logic nr);
        cmd_index = idx; cmd_arg = arg; cmd_no_resp = nr; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Phy side of the command handshake; ack is dropped right after strobe falls.
    task automatic phy_handshake(input int ack_dly);
        wait_sig("strobe_rise", 0, 1'b1);
        repeat (ack_dly) tick();
        ack_in = 1'b1;
        tick();
        wait_sig("strobe_fall", 0, 1'b0);
        ack_in = 1'b0;
    endtask

    task automatic phy_respond(input int dly, input logic [RW-1:0] r, input logic err);
        repeat (dly) tick();
        strobe_in = 1'b1; response = r; resp_error = err;
        wait_sig("ack_rise", 1, 1'b1);
        strobe_in = 1'b0; resp_error = 1'b0;
        wait_sig("ack_fall", 1, 1'b0);
    endtask

    task automatic collect(input logic [5:0] idx, input logic [RW-1:0] d,
                           input logic [1:0] st, input int rdy_dly);
        wait_sig("rsp_valid", 2, 1'b1);
        chk("rsp_index", rsp_idx, idx);
        chk("rsp_data", rsp_data, d);
        chk("rsp_status", rsp_status, st);
        repeat (rdy_dly) tick();
        chk("rsp_hold", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, sbase, n;
        logic [RW-1:0] r1, r2;

        repeat (3) tick();
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_strobe", strobe_out, 1'b0);
        chk("rst_ack", ack_out, 1'b0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", qcount, 0);
        chk("rst_rspdata", rsp_data, 0);
        rst_n = 1'b1;
        tick();

        // CMD5: push-to-strobe latency and a clean response
        push(6'd5, 32'h5, 1'b0);
        chk("lat_n_strobe", strobe_out, 1'b0);
        chk("lat_n_count", qcount, 1);
        tick();
        chk("lat_n1_strobe", strobe_out, 1'b1);
        chk("lat_n1_count", qcount, 0);
        chk("lat_busy", busy, 1'b1);
        chk("cmd_index", o_idx, 6'd5);
        chk("cmd_arg", o_arg, 32'h5);
        phy_handshake(3);
        phy_respond(10, 38'h2A_DEADBEEF, 1'b0);
        collect(6'd5, 38'h2A_DEADBEEF, OK, 2);

        // CMD0 with no response: no host ack pulse
        base = ack_rises; sbase = strobe_rises;
        push(6'd0, 32'h0, 1'b1);
        phy_handshake(1);
        collect(6'd0, '0, OK, 0);
        chk("cmd0_ackpulses", ack_rises - base, 0);
        chk("cmd0_issues", strobe_rises - sbase, 1);

        // Phy never responds: three attempts, each WAIT_RSP lasting TOUT cycles
        sbase = strobe_rises;
        push(6'd8, 32'hCAFE_0008, 1'b0);
        for (int a = 0; a <= MAXR; a++) begin
            phy_handshake(0);
            n = 0;
            while (!strobe_out && !rsp_valid && n < 100) begin
                tick();
                n++;
            end
            chk("to_window", n, TOUT + 2);
        end
        collect(6'd8, '0, TO, 0);
        chk("to_issues", strobe_rises - sbase, MAXR + 1);

        // Error then clean response, the clean one landing in the final timer cycle
        r1 = {6'h11, 32'h1111_2222};
        r2 = {6'h22, 32'h3333_4444};
        sbase = strobe_rises;
        push(6'd17, 32'h17, 1'b0);
        phy_handshake(2);
        phy_respond(4, r1, 1'b1);
        phy_handshake(1);
        phy_respond(TOUT, r2, 1'b0);
        collect(6'd17, r2, OK, 0);
        chk("err_issues", strobe_rises - sbase, 2);

        // Queue fill while the FSM is stalled in ISSUE
        begin
            logic [5:0] exp_q[$];
            push(6'd40, 32'h40, 1'b1);
            wait_sig("fill_stall", 0, 1'b1);
            for (int i = 0; i < 5; i++) begin
                cmd_index = 6'(41 + i); cmd_arg = 32'(i); cmd_no_resp = 1'b1; cmd_valid = 1'b1;
                chk("fill_ready", cmd_ready, (exp_q.size() < DEPTH));
                if (exp_q.size() < DEPTH) exp_q.push_back(6'(41 + i));
                tick();
            end
            cmd_valid = 1'b0;
            chk("fill_count", qcount, DEPTH);
            chk("fill_notready", cmd_ready, 1'b0);
            phy_handshake(0);
            collect(6'd40, '0, OK, 0);
            for (int k = 0; k < DEPTH; k++) begin
                wait_sig("fill_pop", 0, 1'b1);
                chk("fill_popcount", qcount, DEPTH - 1 - k);
                phy_handshake(0);
                collect(exp_q.pop_front(), '0, OK, 0);
            end
            repeat (3) tick();
            chk("fill_idle", busy, 1'b0);
            chk("fill_empty", qcount, 0);
        end

        // Random commands against an attempt-level model
        for (int t = 0; t < 40; t++) begin
            logic [5:0]    idx;
            logic [31:0]   arg;
            logic          nr;
            int            mode[MAXR+1];
            logic [RW-1:0] rs[MAXR+1];
            int            exp_iss;
            logic [1:0]    exp_st;
            logic [RW-1:0] exp_d;
            bit            done;
            idx = 6'($urandom);
            arg = $urandom;
            nr  = ($urandom_range(0, 3) == 0);
            for (int a = 0; a <= MAXR; a++) begin
                int p = $urandom_range(0, 3);
                mode[a] = (p < 2) ? 0 : (p == 2) ? 1 : 2;   // 0 ok, 1 error, 2 silent
                rs[a] = {6'($urandom), 32'($urandom)};
            end
            exp_iss = 0; exp_st = OK; exp_d = '0; done = 0;
            for (int a = 0; a <= MAXR && !done; a++) begin
                exp_iss++;
                if (nr)               begin exp_st = OK; exp_d = '0;    done = 1; end
                else if (mode[a] == 0) begin exp_st = OK; exp_d = rs[a]; done = 1; end
                else if (mode[a] == 1) begin exp_st = ER; exp_d = rs[a]; end
                else                   begin exp_st = TO; exp_d = '0;    end
            end
            sbase = strobe_rises;
            push(idx, arg, nr);
            for (int a = 0; a <= MAXR; a++) begin
                n = 0;
                while (!strobe_out && !rsp_valid && n < 100) begin
                    tick();
                    n++;
                end
                if (rsp_valid || !strobe_out) break;
                chk("rnd_arg", o_arg, arg);
                phy_handshake($urandom_range(0, 3));
                if (!nr && mode[a] != 2)
                    phy_respond($urandom_range(0, TOUT), rs[a], (mode[a] == 1));
            end
            collect(idx, exp_d, exp_st, $urandom_range(0, 2));
            chk("rnd_issues", strobe_rises - sbase, exp_iss);
        end

        // Reset asserted while the host ack is high
        push(6'd9, 32'h9, 1'b0);
        push(6'd10, 32'hA, 1'b0);
        push(6'd11, 32'hB, 1'b0);
        phy_handshake(0);
        strobe_in = 1'b1; response = 38'h1;
        wait_sig("rst_ackrsp", 1, 1'b1);
        chk("rst_pre_count", qcount, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ack", ack_out, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_valid", rsp_valid, 1'b0);
        chk("arst_strobe", strobe_out, 1'b0);
        chk("arst_count", qcount, 0);
        chk("arst_ready", cmd_ready, 1'b1);
        strobe_in = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("arst_stays_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
